// File: rtl/seq_div.sv
// seq_div: sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request, sampled only while busy=0
//   dividend       : unsigned dividend, captured when start is accepted
//   divisor        : unsigned divisor, captured when start is accepted
//   busy           : high while an iterative division is in progress
//   done           : single-cycle completion pulse
//   quotient       : registered quotient, held until the next completion
//   remainder      : registered remainder, held until the next completion
//   div_by_zero    : set at completion when the divisor was zero
module seq_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem;       // partial remainder
  logic [WIDTH-1:0] dvd;        // working dividend, quotient shifts in at LSB
  logic [WIDTH-1:0] dvs;
  logic             dz_pend;    // divide-by-zero result due on next edge

  logic [WIDTH+1:0] prem_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   prem_nxt;
  logic [WIDTH-1:0] dvd_nxt;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && (divisor != '0)) state_nxt = S_RUN;
      S_RUN:   if (cnt == CW'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One restoring iteration: shift, trial-subtract, keep or restore
  always_comb begin
    prem_sh  = {prem, dvd[WIDTH-1]};
    diff     = prem_sh - {2'b00, dvs};
    prem_nxt = diff[WIDTH+1] ? prem_sh[WIDTH:0] : diff[WIDTH:0];
    dvd_nxt  = {dvd[WIDTH-2:0], ~diff[WIDTH+1]};
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      prem        <= '0;
      dvd         <= '0;
      dvs         <= '0;
      dz_pend     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == S_RUN);
      done    <= 1'b0;
      dz_pend <= 1'b0;

      // dvd still holds the dividend captured on the previous edge
      if (dz_pend) begin
        quotient    <= '1;
        remainder   <= dvd;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            dvd     <= dividend;
            dvs     <= divisor;
            prem    <= '0;
            cnt     <= CW'(WIDTH);
            dz_pend <= (divisor == '0);
          end
        end
        S_RUN: begin
          prem <= prem_nxt;
          dvd  <= dvd_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient    <= dvd_nxt;
            remainder   <= prem_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
